// File: rtl/button_event_scheduler_pkg.sv
// rtl/button_event_scheduler_pkg.sv - shared state type and reset constants for the button front end
package button_event_scheduler_pkg;

  localparam int unsigned BTN_STATE_W = 2;

  typedef enum logic [BTN_STATE_W-1:0] {
    ST_LOW    = 2'd0,
    ST_ARM_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_ARM_LO = 2'd3
  } btn_state_e;

  localparam btn_state_e BTN_STATE_RST = ST_LOW;
  localparam logic       BTN_LEVEL_RST = 1'b0;

  // Event id width; a single-channel build still carries a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// rtl/button_event_scheduler_if.sv - valid/ready button event port
interface button_event_scheduler_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_long;

  modport master (output evt_valid, output evt_id, output evt_long, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_long, output evt_ready);
endinterface

// File: rtl/button_event_scheduler_debounce_channel.sv
// rtl/button_event_scheduler_debounce_channel.sv - one button: synchronizer, tick-driven debounce FSM, rise pulse, optional hold counter (LONG_PRESS_EN)
module button_event_scheduler_debounce_channel
  import button_event_scheduler_pkg::*;
#(
  parameter int STABLE_TICKS = 4
`ifdef LONG_PRESS_EN
  , parameter int LONG_TICKS = 64
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  input  logic tick,
  output logic debounced,
  output logic rise
`ifdef LONG_PRESS_EN
  , output logic long_hit
`endif
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Two-flop synchronizer for the raw asynchronous level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= BTN_LEVEL_RST;
      sync2_q <= BTN_LEVEL_RST;
    end else begin
      sync1_q <= noisy;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a new level must be seen on STABLE_TICKS consecutive ticks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        ST_LOW: begin
          if (sync2_q) begin
            if (STABLE_TICKS == 1) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARM_HI;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_ARM_HI: begin
          if (!sync2_q) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (int'(cnt_q) + 1 >= STABLE_TICKS) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync2_q) begin
            if (STABLE_TICKS == 1) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARM_LO;
              cnt_d   = CW'(1);
            end
          end
        end
        default: begin
          if (sync2_q) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (int'(cnt_q) + 1 >= STABLE_TICKS) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
    rise_d = tick && (state_q == ST_LOW || state_q == ST_ARM_HI) && (state_d == ST_HIGH);
  end

  // FSM state, stability counter and registered rise pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BTN_STATE_RST;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign debounced = (state_q == ST_HIGH) || (state_q == ST_ARM_LO);
  assign rise      = rise_q;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold counter: ticks spent debounced-high, saturating; fires once on reaching LONG_TICKS
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (tick) begin
      if (state_q == ST_LOW) begin
        hold_d = '0;
      end else if (debounced && int'(hold_q) < LONG_TICKS) begin
        hold_d = hold_q + 1'b1;
        long_d = (int'(hold_q) + 1 == LONG_TICKS);
      end
    end
  end

  // Hold counter and long-press pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_hit = long_q;
`endif

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - N-button debounce front end with round-robin event port; LONG_PRESS_EN adds long-press events
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BTN-1:0]          noisy,
  output logic [N_BTN-1:0]          debounced,
  button_event_scheduler_if.master  evt,
  output logic                      overflow
);

  localparam int ID_W = id_width(N_BTN);
  localparam int TW   = $clog2(TICK_DIV);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] lpend_q;
  logic [N_BTN-1:0] grant_p;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic             evt_long_q, evt_long_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic             overflow_q, overflow_d;
  logic             arb_en;
  logic             found;
  int               idx;

`ifdef LONG_PRESS_EN
  logic [N_BTN-1:0] long_hit;
  logic [N_BTN-1:0] lpend_d;
  logic [N_BTN-1:0] grant_l;
`endif

  // Shared sample-tick divider: tick is high on the last count before wrap
  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_event_scheduler_debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
`ifdef LONG_PRESS_EN
      , .LONG_TICKS (LONG_TICKS)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .noisy     (noisy[i]),
      .tick      (tick),
      .debounced (debounced[i]),
      .rise      (rise[i])
`ifdef LONG_PRESS_EN
      , .long_hit (long_hit[i])
`endif
    );
  end

  // Round-robin arbiter: reload the port when idle or when the current event is taken
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_long_d  = evt_long_q;
    rr_d        = rr_q;
    grant_p     = '0;
`ifdef LONG_PRESS_EN
    grant_l     = '0;
`endif
    found       = 1'b0;
    idx         = 0;
    arb_en      = !evt_valid_q || evt.evt_ready;
    if (arb_en) begin
      evt_valid_d = 1'b0;
      for (int k = 0; k < N_BTN; k++) begin
        idx = (int'(rr_q) + k) % N_BTN;
        if (!found && (pend_q[idx] || lpend_q[idx])) begin
          found       = 1'b1;
          evt_valid_d = 1'b1;
          evt_id_d    = ID_W'(idx);
          evt_long_d  = !pend_q[idx];
          rr_d        = ID_W'((idx + 1) % N_BTN);
          if (pend_q[idx]) begin
            grant_p[idx] = 1'b1;
          end
`ifdef LONG_PRESS_EN
          else begin
            grant_l[idx] = 1'b1;
          end
`endif
        end
      end
    end
  end

  // Pending bookkeeping: a new event wins over a same-cycle grant; a duplicate is dropped
  always_comb begin
    pend_d     = (pend_q & ~grant_p) | rise;
    overflow_d = |(rise & pend_q & ~grant_p);
`ifdef LONG_PRESS_EN
    lpend_d    = (lpend_q & ~grant_l) | long_hit;
    overflow_d = overflow_d | (|(long_hit & lpend_q & ~grant_l));
`endif
  end

`ifdef LONG_PRESS_EN
  // Long-press pending bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lpend_q <= '0;
    end else begin
      lpend_q <= lpend_d;
    end
  end
`else
  // No long-press sources in this build; LONG_TICKS has no effect
  assign lpend_q = {N_BTN{LONG_TICKS < 0}};
`endif

  // Tick counter, press pending bits, event port and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q  <= '0;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_long_q  <= 1'b0;
      rr_q        <= '0;
      overflow_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_long_q  <= evt_long_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;
  assign evt.evt_long  = evt_long_q;
  assign overflow      = overflow_q;

endmodule
